// File: rtl/scan_pkg.sv
// Shared constants, FSM state type and row-step rule for the LED-matrix scan capture block.
package scan_pkg;

   localparam int X_W_DEF     = 3;
   localparam int Y_W_DEF     = 4;
   localparam int ROWS        = 2 ** Y_W_DEF;
   localparam int COLS        = 2 ** X_W_DEF;
   localparam int TIMEOUT_DEF = 32767;
   localparam int CNT_W       = 15;

   typedef enum logic {
      SYNC = 1'b0,
      CAPT = 1'b1
   } scan_state_e;

   // The scanner walks rows downward and may linger on a row; 0 -> 15 wraps modulo ROWS.
   function automatic logic legal_step(input logic [Y_W_DEF-1:0] last_y,
                                       input logic [Y_W_DEF-1:0] y_in);
      logic [Y_W_DEF-1:0] prev_y;
      prev_y = last_y - {{(Y_W_DEF-1){1'b0}}, 1'b1};
      return (y_in == last_y) || (y_in == prev_y);
   endfunction

endpackage

// File: rtl/scan_row_buffer.sv
// Work/display bitmap pair: the work buffer accumulates the frame being scanned, commit copies
// it to the display buffer, which is read back one row per cycle through a registered port.
module scan_row_buffer
   import scan_pkg::*;
#(
   parameter int X_W = X_W_DEF,
   parameter int Y_W = Y_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 set_en,
   input  logic [X_W-1:0]       set_x,
   input  logic [Y_W-1:0]       set_y,
   input  logic                 clr_work,
   input  logic                 commit,
   input  logic [Y_W-1:0]       rd_row,
   output logic [(2**X_W)-1:0]  rd_bits
);

   localparam int NROW = 2 ** Y_W;
   localparam int NCOL = 2 ** X_W;

   logic [NCOL-1:0] work_q    [NROW];
   logic [NCOL-1:0] work_d    [NROW];
   logic [NCOL-1:0] display_q [NROW];
   logic [NCOL-1:0] display_d [NROW];
   logic [NCOL-1:0] rd_bits_q;
   logic [NCOL-1:0] rd_bits_d;

   // Clear is applied before set so a commit strobe lands its own pixel in the fresh frame.
   always_comb begin
      work_d    = work_q;
      display_d = display_q;
      if (commit) begin
         display_d = work_q;
      end
      if (clr_work) begin
         for (int r = 0; r < NROW; r++) begin
            work_d[r] = '0;
         end
      end
      if (set_en) begin
         work_d[set_y][set_x] = 1'b1;
      end
      rd_bits_d = display_q[rd_row];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NROW; r++) begin
            work_q[r]    <= '0;
            display_q[r] <= '0;
         end
         rd_bits_q <= '0;
      end else begin
         work_q    <= work_d;
         display_q <= display_d;
         rd_bits_q <= rd_bits_d;
      end
   end

   assign rd_bits = rd_bits_q;

endmodule

// File: rtl/scan_frame_capture.sv
// Rebuilds lit-pixel frames from the scanner's (x,y) strobe stream, with sync/sequence/timeout
// tracking. Optional CAPTURE_STATS_EN adds frame and error counters.
module scan_frame_capture
   import scan_pkg::*;
#(
   parameter int X_W     = X_W_DEF,
   parameter int Y_W     = Y_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                inStb,
   input  logic [X_W-1:0]      xIn,
   input  logic [Y_W-1:0]      yIn,
   input  logic [Y_W-1:0]      rdRow,
   output logic [(2**X_W)-1:0] rdBits,
   output logic                frameDone,
   output logic                synced,
   output logic                seqErr,
   output logic                toErr,
   input  logic                errClr
`ifdef CAPTURE_STATS_EN
   ,
   output logic [7:0]          frameCnt,
   output logic [7:0]          errCnt
`endif
);

   // inStb is a one-cycle strobe with no backpressure: xIn/yIn are consumed on that edge.
   scan_state_e      state_q, state_d;
   logic [Y_W-1:0]   last_y_q, last_y_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic             seq_err_q, seq_err_d;
   logic             to_err_q, to_err_d;
   logic             frame_done_q, frame_done_d;
   logic             set_en, clr_work, commit;

   always_comb begin
      state_d      = state_q;
      last_y_d     = last_y_q;
      to_cnt_d     = to_cnt_q;
      seq_err_d    = seq_err_q & ~errClr;
      to_err_d     = to_err_q & ~errClr;
      frame_done_d = 1'b0;
      set_en       = 1'b0;
      clr_work     = 1'b0;
      commit       = 1'b0;
      case (state_q)
         SYNC: begin
            to_cnt_d = '0;
            if (inStb && (yIn == '1)) begin
               state_d  = CAPT;
               set_en   = 1'b1;
               last_y_d = yIn;
            end
         end
         CAPT: begin
            if (inStb) begin
               to_cnt_d = '0;
               // Wrap must be tested before the generic step rule, which also accepts 0 -> 15.
               if ((last_y_q == '0) && (yIn == '1)) begin
                  commit       = 1'b1;
                  clr_work     = 1'b1;
                  set_en       = 1'b1;
                  frame_done_d = 1'b1;
                  last_y_d     = yIn;
               end else if (legal_step(last_y_q, yIn)) begin
                  set_en   = 1'b1;
                  last_y_d = yIn;
               end else begin
                  seq_err_d = 1'b1;
                  clr_work  = 1'b1;
                  state_d   = SYNC;
               end
            end else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
               to_err_d = 1'b1;
               clr_work = 1'b1;
               to_cnt_d = '0;
               state_d  = SYNC;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q      <= SYNC;
         last_y_q     <= '0;
         to_cnt_q     <= '0;
         seq_err_q    <= 1'b0;
         to_err_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_y_q     <= last_y_d;
         to_cnt_q     <= to_cnt_d;
         seq_err_q    <= seq_err_d;
         to_err_q     <= to_err_d;
         frame_done_q <= frame_done_d;
      end
   end

   scan_row_buffer #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_row_buffer (
      .clk      (CLK),
      .rst_n    (RSTn),
      .set_en   (set_en),
      .set_x    (xIn),
      .set_y    (yIn),
      .clr_work (clr_work),
      .commit   (commit),
      .rd_row   (rdRow),
      .rd_bits  (rdBits)
   );

   assign frameDone = frame_done_q;
   assign synced    = (state_q == CAPT);
   assign seqErr    = seq_err_q;
   assign toErr     = to_err_q;

`ifdef CAPTURE_STATS_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   // Every error event (sequence or timeout) is exactly a CAPT -> SYNC transition.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (commit) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
      if ((state_q == CAPT) && (state_d == SYNC) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign frameCnt = frame_cnt_q;
   assign errCnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_scan_frame_capture.sv
// Directed bench for scan_frame_capture: sync hunt, frame rebuild, commit/read overlap, errors.
module tb_scan_frame_capture;

   logic       clk;
   logic       rst_n;
   logic       in_stb;
   logic [2:0] x_in;
   logic [3:0] y_in;
   logic [3:0] rd_row;
   logic [7:0] rd_bits;
   logic       frame_done;
   logic       synced;
   logic       seq_err;
   logic       to_err;
   logic       err_clr;
`ifdef CAPTURE_STATS_EN
   logic [7:0] frame_cnt;
   logic [7:0] err_cnt;
`endif

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [7:0] exp_q[$];

   scan_frame_capture dut (
      .CLK       (clk),
      .RSTn      (rst_n),
      .inStb     (in_stb),
      .xIn       (x_in),
      .yIn       (y_in),
      .rdRow     (rd_row),
      .rdBits    (rd_bits),
      .frameDone (frame_done),
      .synced    (synced),
      .seqErr    (seq_err),
      .toErr     (to_err),
      .errClr    (err_clr)
`ifdef CAPTURE_STATS_EN
      ,
      .frameCnt  (frame_cnt),
      .errCnt    (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      in_stb  = 1'b0;
      x_in    = '0;
      y_in    = '0;
      rd_row  = '0;
      err_clr = 1'b0;
      idle(3);
      rst_n = 1'b1;
   endtask

   task automatic strobe(input logic [2:0] x, input logic [3:0] y);
      in_stb = 1'b1;
      x_in   = x;
      y_in   = y;
      idle(1);
      in_stb = 1'b0;
   endtask

   task automatic read_all(input string tag);
      logic [7:0] exp;
      for (int r = 0; r < 16; r++) begin
         rd_row = 4'(r);
         idle(1);
         exp = exp_q.pop_front();
         chk_cnt++;
         if (rd_bits !== exp) $display("FAIL %s_row%0d got=%h exp=%h", tag, r, rd_bits, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      chk_cnt++; if (rd_bits !== 8'h00) $display("FAIL reset_rdbits got=%h exp=00", rd_bits); else pass_cnt++;
      chk_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_framedone got=%b exp=0", frame_done); else pass_cnt++;
      chk_cnt++; if (synced !== 1'b0) $display("FAIL reset_synced got=%b exp=0", synced); else pass_cnt++;
      chk_cnt++; if (seq_err !== 1'b0) $display("FAIL reset_seqerr got=%b exp=0", seq_err); else pass_cnt++;
      chk_cnt++; if (to_err !== 1'b0) $display("FAIL reset_toerr got=%b exp=0", to_err); else pass_cnt++;
   endtask

   task automatic test_sync_hunt();
      strobe(3'd1, 4'd7);
      chk_cnt++; if (synced !== 1'b0) $display("FAIL hunt_y7 got=%b exp=0", synced); else pass_cnt++;
      strobe(3'd1, 4'd6);
      chk_cnt++; if (synced !== 1'b0) $display("FAIL hunt_y6 got=%b exp=0", synced); else pass_cnt++;
      strobe(3'd1, 4'd15);
      chk_cnt++; if (synced !== 1'b1) $display("FAIL hunt_y15 got=%b exp=1", synced); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_frame_stream();
      int early = 0;
      strobe(3'd2, 4'd15);
      for (int y = 14; y >= 0; y--) begin
         idle((y == 7) ? 10000 : 20);
         strobe(3'd2, 4'(y));
         if (frame_done) early++;
         if (y == 14) begin
            strobe(3'd2, 4'd14);
            if (frame_done) early++;
         end
      end
      chk_cnt++; if (early !== 0) $display("FAIL stream_early_done got=%0d exp=0", early); else pass_cnt++;
      chk_cnt++; if (synced !== 1'b1) $display("FAIL stream_synced got=%b exp=1", synced); else pass_cnt++;
      idle(20);
      strobe(3'd5, 4'd15);
      chk_cnt++; if (frame_done !== 1'b1) $display("FAIL stream_done got=%b exp=1", frame_done); else pass_cnt++;
      idle(1);
      chk_cnt++; if (frame_done !== 1'b0) $display("FAIL stream_done_once got=%b exp=0", frame_done); else pass_cnt++;
      for (int r = 0; r < 16; r++) exp_q.push_back(8'h04);
      read_all("frame1");
   endtask

   task automatic test_commit_read();
      for (int y = 14; y >= 0; y--) begin
         strobe(3'(y % 8), 4'(y));
         if (y == 14) strobe(3'd6, 4'd14);
      end
      strobe(3'd0, 4'd0);
      strobe(3'd0, 4'd0);
      rd_row = 4'd3;
      strobe(3'd6, 4'd15);
      chk_cnt++; if (rd_bits !== 8'h04) $display("FAIL commit_read_old got=%h exp=04", rd_bits); else pass_cnt++;
      chk_cnt++; if (frame_done !== 1'b1) $display("FAIL commit_done got=%b exp=1", frame_done); else pass_cnt++;
      idle(1);
      chk_cnt++; if (rd_bits !== 8'h08) $display("FAIL commit_read_new got=%h exp=08", rd_bits); else pass_cnt++;
      // row y carries column y%8; row 15 holds the pixel of the previous wrap strobe (x=5)
      for (int r = 0; r < 15; r++) exp_q.push_back(8'(1 << (r % 8)));
      exp_q.push_back(8'h20);
      read_all("frame2");
   endtask

   task automatic test_seq_err();
      for (int y = 14; y >= 9; y--) strobe(3'd1, 4'(y));
      chk_cnt++; if (synced !== 1'b1) $display("FAIL seq_presynced got=%b exp=1", synced); else pass_cnt++;
      err_clr = 1'b1;
      strobe(3'd1, 4'd5);
      err_clr = 1'b0;
      chk_cnt++; if (seq_err !== 1'b1) $display("FAIL seq_set_over_clr got=%b exp=1", seq_err); else pass_cnt++;
      chk_cnt++; if (synced !== 1'b0) $display("FAIL seq_unsynced got=%b exp=0", synced); else pass_cnt++;
      strobe(3'd1, 4'd14);
      chk_cnt++; if (synced !== 1'b0) $display("FAIL seq_ignore_y14 got=%b exp=0", synced); else pass_cnt++;
      chk_cnt++; if (seq_err !== 1'b1) $display("FAIL seq_sticky got=%b exp=1", seq_err); else pass_cnt++;
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk_cnt++; if (seq_err !== 1'b0) $display("FAIL seq_clr got=%b exp=0", seq_err); else pass_cnt++;
      rd_row = 4'd3;
      idle(1);
      chk_cnt++; if (rd_bits !== 8'h08) $display("FAIL seq_display_kept got=%h exp=08", rd_bits); else pass_cnt++;
   endtask

   task automatic test_timeout();
      strobe(3'd0, 4'd15);
      chk_cnt++; if (synced !== 1'b1) $display("FAIL to_synced got=%b exp=1", synced); else pass_cnt++;
      idle(32766);
      chk_cnt++; if (to_err !== 1'b0) $display("FAIL to_early got=%b exp=0", to_err); else pass_cnt++;
      chk_cnt++; if (synced !== 1'b1) $display("FAIL to_still_synced got=%b exp=1", synced); else pass_cnt++;
      idle(1);
      chk_cnt++; if (to_err !== 1'b1) $display("FAIL to_set got=%b exp=1", to_err); else pass_cnt++;
      chk_cnt++; if (synced !== 1'b0) $display("FAIL to_unsynced got=%b exp=0", synced); else pass_cnt++;
      chk_cnt++; if (seq_err !== 1'b0) $display("FAIL to_no_seqerr got=%b exp=0", seq_err); else pass_cnt++;
      rd_row = 4'd5;
      idle(1);
      chk_cnt++; if (rd_bits !== 8'h20) $display("FAIL to_display_kept got=%h exp=20", rd_bits); else pass_cnt++;
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk_cnt++; if (to_err !== 1'b0) $display("FAIL to_clr got=%b exp=0", to_err); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      strobe(3'd1, 4'd15);
      for (int y = 14; y >= 0; y--) strobe(3'd4, 4'(y));
      strobe(3'd0, 4'd15);
      chk_cnt++; if (frame_done !== 1'b1) $display("FAIL b2b_done got=%b exp=1", frame_done); else pass_cnt++;
      for (int r = 0; r < 15; r++) exp_q.push_back(8'h10);
      exp_q.push_back(8'h02);
      read_all("b2b");
   endtask

   task automatic test_mid_reset();
      strobe(3'd3, 4'd15);
      strobe(3'd3, 4'd14);
      do_reset();
      chk_cnt++; if (synced !== 1'b0) $display("FAIL midrst_synced got=%b exp=0", synced); else pass_cnt++;
      for (int r = 0; r < 16; r++) exp_q.push_back(8'h00);
      read_all("midrst");
   endtask

`ifdef CAPTURE_STATS_EN
   task automatic test_stats();
      do_reset();
      chk_cnt++; if (err_cnt !== 8'd0) $display("FAIL stats_err_reset got=%0d exp=0", err_cnt); else pass_cnt++;
      chk_cnt++; if (frame_cnt !== 8'd0) $display("FAIL stats_frame_reset got=%0d exp=0", frame_cnt); else pass_cnt++;
      for (int i = 0; i < 300; i++) begin
         strobe(3'd0, 4'd15);
         strobe(3'd0, 4'd5);
      end
      chk_cnt++; if (err_cnt !== 8'd255) $display("FAIL stats_err_sat got=%0d exp=255", err_cnt); else pass_cnt++;
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk_cnt++; if (err_cnt !== 8'd255) $display("FAIL stats_err_clr got=%0d exp=255", err_cnt); else pass_cnt++;
      strobe(3'd0, 4'd15);
      for (int f = 0; f < 256; f++) begin
         for (int y = 14; y >= 0; y--) strobe(3'd0, 4'(y));
         strobe(3'd0, 4'd15);
         if (f == 254) begin
            chk_cnt++; if (frame_cnt !== 8'd255) $display("FAIL stats_frame_255 got=%0d exp=255", frame_cnt); else pass_cnt++;
         end
      end
      chk_cnt++; if (frame_cnt !== 8'd0) $display("FAIL stats_frame_wrap got=%0d exp=0", frame_cnt); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_sync_hunt();
      test_frame_stream();
      test_commit_read();
      test_seq_err();
      test_timeout();
      test_back_to_back();
      test_mid_reset();
`ifdef CAPTURE_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
